// File: rtl/vga_dither_pkg.sv
// Shared constants and helpers for the VGA ordered-dither output stage:
// 4x4 Bayer ROM, sync idle level and the Bayer-to-threshold scaling.
package vga_dither_pkg;

    localparam logic SYNC_ACTIVE_LOW   = 1'b0;
    localparam logic SYNC_IDLE_DEFAULT = ~SYNC_ACTIVE_LOW;

    // Indexed by {y[1:0], x[1:0]}: row = y, column = x.
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic sync_idle(input logic active);
        return ~active;
    endfunction

    // Scale a 0..15 Bayer value to the d dropped bits so it spans 0..2^d-1.
    function automatic logic [31:0] threshold(input logic [3:0] b, input int d);
        if (d >= 4)
            return 32'(b) << (d - 4);
        else if (d > 0)
            return 32'(b >> (4 - d));
        else
            return '0;
    endfunction

endpackage

// File: rtl/vga_dither_chan.sv
// One colour channel of the dither pipe: add threshold, drop low bits,
// saturate, and blank when the aligned DE is low.
module vga_dither_chan
    import vga_dither_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_p1,
    input  logic [IN_BITS-1:0]  pix_p0,
    input  logic [IN_BITS-1:0]  thr_p0,
    output logic [OUT_BITS-1:0] pix_p2
);

    localparam int D = IN_BITS - OUT_BITS;

    logic [IN_BITS:0] sum_p1;

    // The extra sum bit is the overflow flag after the shift.
    function automatic logic [OUT_BITS-1:0] saturate(input logic [IN_BITS:0] s);
        logic [OUT_BITS:0] q;
        q = s[IN_BITS:D];
        return q[OUT_BITS] ? '1 : q[OUT_BITS-1:0];
    endfunction

    // p0 -> p1: threshold add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_p1 <= '0;
        else
            sum_p1 <= {1'b0, pix_p0} + {1'b0, thr_p0};
    end

    // p1 -> p2: shift, saturate, blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_p2 <= '0;
        else
            pix_p2 <= vld_p1 ? saturate(sum_p1) : '0;
    end

endmodule

// File: rtl/vga_dither_out.sv
// VGA output stage: 4x4 ordered dither from IN_BITS to OUT_BITS per channel
// with syncs/DE delayed to match. VGA_DITHER_TEMPORAL_EN rotates the pattern per frame.
module vga_dither_out
    import vga_dither_pkg::*;
#(
    parameter int   IN_BITS     = 8,
    parameter int   OUT_BITS    = 4,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_LOW,
    parameter int   X_BITS      = 10,
    parameter int   Y_BITS      = 10
) (
    input  logic                CLK_25MHZ,
    input  logic                RESET_N,
    input  logic                VGA_HSYNC_IN,
    input  logic                VGA_VSYNC_IN,
    input  logic                VGA_DE_IN,
    input  logic [IN_BITS-1:0]  VGA_RED_IN,
    input  logic [IN_BITS-1:0]  VGA_GREEN_IN,
    input  logic [IN_BITS-1:0]  VGA_BLUE_IN,
    output logic                VGA_HSYNC,
    output logic                VGA_VSYNC,
    output logic                VGA_DE,
    output logic [OUT_BITS-1:0] VGA_RED,
    output logic [OUT_BITS-1:0] VGA_GREEN,
    output logic [OUT_BITS-1:0] VGA_BLUE
);

    localparam int   D         = IN_BITS - OUT_BITS;
    localparam logic SYNC_IDLE = sync_idle(SYNC_ACTIVE);

    logic [X_BITS-1:0]  x_p0;
    logic [Y_BITS-1:0]  y_p0;
    logic               de_prev;
    logic               vs_prev;
    logic               vs_edge;
    logic               de_fall;
    logic [1:0]         frame_xor;
    logic [3:0]         idx_p0;
    logic [IN_BITS-1:0] thr_p0;
    logic               hs_p1, vs_p1, vld_p1;
    logic               hs_p2, vs_p2, vld_p2;

    assign vs_edge = (VGA_VSYNC_IN == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);
    assign de_fall = de_prev && !VGA_DE_IN;

    // p0: position tracking; the pixel on this cycle uses the current x/y.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            x_p0    <= '0;
            y_p0    <= '0;
            de_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            de_prev <= VGA_DE_IN;
            vs_prev <= VGA_VSYNC_IN;
            if (VGA_DE_IN)
                x_p0 <= x_p0 + X_BITS'(1);
            else if (de_prev)
                x_p0 <= '0;
            if (vs_edge)
                y_p0 <= '0;
            else if (de_fall)
                y_p0 <= y_p0 + Y_BITS'(1);
        end
    end

`ifdef VGA_DITHER_TEMPORAL_EN
    logic [1:0] frame_p0;

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N)
            frame_p0 <= 2'd0;
        else if (vs_edge)
            frame_p0 <= frame_p0 + 2'd1;
    end

    assign frame_xor = frame_p0;
`else
    assign frame_xor = 2'd0;
`endif

    assign idx_p0 = {y_p0[1:0] ^ frame_xor, x_p0[1:0] ^ frame_xor};
    assign thr_p0 = IN_BITS'(threshold(BAYER4[idx_p0], D));

    // p0 -> p1 -> p2: sync/DE ride alongside the colour pipe.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_p1  <= SYNC_IDLE;
            vs_p1  <= SYNC_IDLE;
            vld_p1 <= 1'b0;
            hs_p2  <= SYNC_IDLE;
            vs_p2  <= SYNC_IDLE;
            vld_p2 <= 1'b0;
        end else begin
            hs_p1  <= VGA_HSYNC_IN;
            vs_p1  <= VGA_VSYNC_IN;
            vld_p1 <= VGA_DE_IN;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            vld_p2 <= vld_p1;
        end
    end

    assign VGA_HSYNC = hs_p2;
    assign VGA_VSYNC = vs_p2;
    assign VGA_DE    = vld_p2;

    vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_red (
        .clk    (CLK_25MHZ),
        .rst_n  (RESET_N),
        .vld_p1 (vld_p1),
        .pix_p0 (VGA_RED_IN),
        .thr_p0 (thr_p0),
        .pix_p2 (VGA_RED)
    );

    vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_green (
        .clk    (CLK_25MHZ),
        .rst_n  (RESET_N),
        .vld_p1 (vld_p1),
        .pix_p0 (VGA_GREEN_IN),
        .thr_p0 (thr_p0),
        .pix_p2 (VGA_GREEN)
    );

    vga_dither_chan #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_blue (
        .clk    (CLK_25MHZ),
        .rst_n  (RESET_N),
        .vld_p1 (vld_p1),
        .pix_p0 (VGA_BLUE_IN),
        .thr_p0 (thr_p0),
        .pix_p2 (VGA_BLUE)
    );

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out: an 8->4 dithered instance and an
// 8->8 passthrough instance share stimulus; expectations come from a reference model.
module tb_vga_dither_out;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic       hs_o, vs_o, de_o;
    logic [3:0] r_o, g_o, b_o;
    logic       hs_o8, vs_o8, de_o8;
    logic [7:0] r_o8, g_o8, b_o8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_dither_out dut (
        .CLK_25MHZ(clk), .RESET_N(rst_n),
        .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in), .VGA_DE_IN(de_in),
        .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
        .VGA_HSYNC(hs_o), .VGA_VSYNC(vs_o), .VGA_DE(de_o),
        .VGA_RED(r_o), .VGA_GREEN(g_o), .VGA_BLUE(b_o)
    );

    vga_dither_out #(.OUT_BITS(8)) dut8 (
        .CLK_25MHZ(clk), .RESET_N(rst_n),
        .VGA_HSYNC_IN(hs_in), .VGA_VSYNC_IN(vs_in), .VGA_DE_IN(de_in),
        .VGA_RED_IN(r_in), .VGA_GREEN_IN(g_in), .VGA_BLUE_IN(b_in),
        .VGA_HSYNC(hs_o8), .VGA_VSYNC(vs_o8), .VGA_DE(de_o8),
        .VGA_RED(r_o8), .VGA_GREEN(g_o8), .VGA_BLUE(b_o8)
    );

    typedef struct packed {
        logic       hs, vs, de;
        logic [3:0] r, g, b;
        logic [7:0] pr, pg, pb;
    } exp_t;

    exp_t sb[$];

    localparam logic [3:0] BAY [16] = '{
        4'd0, 4'd8, 4'd2, 4'd10, 4'd12, 4'd4, 4'd14, 4'd6,
        4'd3, 4'd11, 4'd1, 4'd9, 4'd15, 4'd7, 4'd13, 4'd5
    };

    // Reference model state
    logic [9:0] mx, my;
    logic       m_de_prev, m_vs_prev;
    logic [1:0] mf;

    function automatic logic [3:0] dith(input logic [7:0] c, input logic [3:0] t);
        int s;
        s = (int'(c) + int'(t)) >> 4;
        return (s > 15) ? 4'hF : 4'(s);
    endfunction

    task automatic model_reset();
        mx = '0; my = '0; m_de_prev = 1'b0; m_vs_prev = 1'b0; mf = 2'd0;
    endtask

    task automatic drive(input logic hs, input logic vs, input logic de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        logic [3:0] idx;
        logic [3:0] t;
        logic vs_edge;
        hs_in = hs; vs_in = vs; de_in = de; r_in = r; g_in = g; b_in = b;
        idx = {my[1:0] ^ mf, mx[1:0] ^ mf};
        t = BAY[idx];
        e.hs = hs; e.vs = vs; e.de = de;
        e.r = de ? dith(r, t) : 4'h0;
        e.g = de ? dith(g, t) : 4'h0;
        e.b = de ? dith(b, t) : 4'h0;
        e.pr = de ? r : 8'h00;
        e.pg = de ? g : 8'h00;
        e.pb = de ? b : 8'h00;
        sb.push_back(e);
        vs_edge = (vs == 1'b0) && (m_vs_prev == 1'b1);
        if (de) mx = mx + 10'd1;
        else if (m_de_prev) mx = '0;
        if (vs_edge) my = '0;
        else if (m_de_prev && !de) my = my + 10'd1;
`ifdef VGA_DITHER_TEMPORAL_EN
        if (vs_edge) mf = mf + 2'd1;
`endif
        m_de_prev = de;
        m_vs_prev = vs;
    endtask

    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            checks++;
            if ({hs_o, vs_o, de_o} !== {e.hs, e.vs, e.de}) begin
                errors++;
                $display("FAIL sync_de cyc=%0d got hs/vs/de=%b%b%b exp=%b%b%b",
                         cyc, hs_o, vs_o, de_o, e.hs, e.vs, e.de);
            end
            checks++;
            if ({r_o, g_o, b_o} !== {e.r, e.g, e.b}) begin
                errors++;
                $display("FAIL dither_rgb cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                         cyc, r_o, g_o, b_o, e.r, e.g, e.b);
            end
            checks++;
            if ({hs_o8, vs_o8, de_o8, r_o8, g_o8, b_o8} !== {e.hs, e.vs, e.de, e.pr, e.pg, e.pb}) begin
                errors++;
                $display("FAIL passthru cyc=%0d got=%b%b%b %h/%h/%h exp=%b%b%b %h/%h/%h",
                         cyc, hs_o8, vs_o8, de_o8, r_o8, g_o8, b_o8,
                         e.hs, e.vs, e.de, e.pr, e.pg, e.pb);
            end
        end
        drive(hs, vs, de, r, g, b);
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({hs_o, vs_o, de_o, r_o, g_o, b_o} !== {3'b110, 12'h000} ||
            {hs_o8, vs_o8, de_o8, r_o8, g_o8, b_o8} !== {3'b110, 24'h000000}) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b%b%b %h/%h/%h p=%b%b%b %h/%h/%h exp=110 0",
                     tag, cyc, hs_o, vs_o, de_o, r_o, g_o, b_o,
                     hs_o8, vs_o8, de_o8, r_o8, g_o8, b_o8);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        hs_in = $urandom_range(0, 1); vs_in = $urandom_range(0, 1); de_in = 1'b1;
        r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        #1 check_idle("reset_flush");
        repeat (n) begin
            @(negedge clk);
            hs_in = $urandom_range(0, 1); vs_in = $urandom_range(0, 1); de_in = $urandom_range(0, 1);
            r_in = 8'hFF; g_in = 8'($urandom); b_in = 8'($urandom);
            #1 check_idle("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sb.delete();
        sb.push_back({3'b110, 12'h000, 24'h000000});
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic hblank();
        repeat (2) step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h55);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h55);
        repeat (2) step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h55);
    endtask

    task automatic vsync_pulse();
        repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic line(input int n, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) step(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            else     step(1'b1, 1'b1, 1'b1, r, g, b);
        end
        hblank();
    endtask

    task automatic test_reset();
        do_reset(4);
        step(1'b1, 1'b1, 1'b1, 8'h80, 8'h81, 8'hFF);
        idle(3);
    endtask

    task automatic test_dither();
        do_reset(1);
        vsync_pulse();
        line(8, 8'h80, 8'h81, 8'h7F, 1'b0);
        line(8, 8'h80, 8'h81, 8'h7F, 1'b0);
        line(8, 8'h80, 8'h81, 8'h7F, 1'b0);
        line(8, 8'h80, 8'h81, 8'h7F, 1'b0);
    endtask

    task automatic test_saturation();
        vsync_pulse();
        for (int row = 0; row < 4; row++) line(4, 8'hFF, 8'h00, 8'hF8, 1'b0);
    endtask

    task automatic test_blanking();
        idle(6);
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic test_alignment();
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 8'h30);
        step(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        step(1'b1, 1'b1, 1'b1, 8'hC3, 8'h3C, 8'h99);
        step(1'b0, 1'b1, 1'b1, 8'h44, 8'hEE, 8'h01);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        idle(3);
    endtask

    task automatic test_counters();
        vsync_pulse();
        line(640, 8'h00, 8'h00, 8'h00, 1'b1);
        line(640, 8'h00, 8'h00, 8'h00, 1'b1);
        line(4, 8'h81, 8'h8D, 8'h83, 1'b0);
        line(4, 8'h81, 8'h8D, 8'h83, 1'b0);
        vsync_pulse();
        line(4, 8'h81, 8'h8D, 8'h83, 1'b0);
        line(4, 8'h81, 8'h8D, 8'h83, 1'b0);
    endtask

    task automatic test_midreset();
        vsync_pulse();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 8'hF7, 8'h81, 8'h40);
        do_reset(2);
        step(1'b1, 1'b1, 1'b1, 8'h81, 8'hF1, 8'h0F);
        step(1'b1, 1'b1, 1'b1, 8'h81, 8'hF1, 8'h0F);
        hblank();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) != 0),
                 $urandom_range(0, 1), 8'($urandom), 8'($urandom), 8'($urandom));
        idle(3);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dither();
        test_saturation();
        test_blanking();
        test_alignment();
        test_counters();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
